// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and handshake FSM states.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: loads on start, retires one multiplier bit per cycle,
// done is high once all WIDTH bits are consumed and product stays valid until the next start.
module alu_pipe_mul #(
    parameter  int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [RES_W-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [RES_W-1:0] mcand;
    logic [RES_W-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= RES_W'(a);
            acc    <= '0;
            mplier <= b;
            cnt    <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    assign done    = (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// WIDTH-bit ALU with valid/ready on both sides, one-entry output register and an iterative
// multiply. Define ALU_PIPE_FLAGS_EN to add registered zero/carry/overflow flag outputs.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
`ifdef ALU_PIPE_FLAGS_EN
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
`endif
    output alu_state_e       state
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             out_valid_q;
    logic [RES_W-1:0] result_q;
    logic             out_free;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic             load_alu;
    logic             load_mul;
    logic [RES_W-1:0] mul_prod;
    logic [RES_W-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [SH_W-1:0]  shamt;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready never depends on in_valid; the output register may drain and reload in the
    // same cycle, and while out_valid && !out_ready both result and out_valid stay stable.
    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);
    assign load_alu  = accept && (opcode != OP_MUL);

    // Single-cycle datapath
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SH_W-1:0];
    assign shl   = a << shamt;
    assign shr   = a >> shamt;

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = RES_W'(sum);
            OP_SUB:  alu_res = RES_W'(diff);
            OP_AND:  alu_res = RES_W'(a & b);
            OP_OR:   alu_res = RES_W'(a | b);
            OP_XOR:  alu_res = RES_W'(a ^ b);
            OP_SHL:  alu_res = RES_W'(shl);
            OP_SHR:  alu_res = RES_W'(shr);
            default: alu_res = '0;
        endcase
    end

    alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A finished product parks in MUL_DONE when the output register is still occupied.
    always_comb begin
        state_d  = state_q;
        load_mul = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    if (out_free) begin
                        load_mul = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = MUL_DONE;
                    end
                end
            end
            MUL_DONE: begin
                if (out_free) begin
                    load_mul = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
        end else if (load_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_prod;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign state     = state_q;

`ifdef ALU_PIPE_FLAGS_EN
    logic alu_c;
    logic alu_v;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (opcode == OP_ADD) begin
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (opcode == OP_SUB) begin
            alu_c = diff[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (load_alu) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
            flag_v <= alu_v;
        end else if (load_mul) begin
            flag_z <= (mul_prod == '0);
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end
    end
`endif

endmodule
